cxu_l2_requester: RTL and testbench
===================================

// Module: cxu_l2_requester
//
// PURPOSE
// - CPU-side initiator for the CXU-L2 streaming interface: the requester end that drives a mux3_cxu tree or a single CXU.
// - Accepts commands from the core, tags each with a request ID and issues it on req_*.
// - Collects resp_* beats, which may arrive out of order when downstream CXUs have unequal latency.
// - Returns results to the core in strict issue order through a reorder buffer (ROB) of 2**REQ_ID_W slots.
//
// PARAMETERS
// - N_CXUS     3   number of addressable CXUs; CXU_ID_W = $clog2(N_CXUS)
// - N_STATES   1   states per CXU; STATE_ID_W = $clog2(N_STATES), min 1
// - FUNC_ID_W  10  custom function id width, = $bits(cfid_t)
// - DATA_W     32  operand/result width
// - REQ_ID_W   2   request tag width; ROB depth = 2**REQ_ID_W
//
// PORTS
// - clk          in   1           clock
// - rst_n        in   1           reset, asynchronous, active-low
// - cmd_valid    in   1           core command valid
// - cmd_ready    out  1           core command accepted
// - cmd_cxu      in   CXU_ID_W    target CXU
// - cmd_state    in   STATE_ID_W  target state context
// - cmd_func     in   FUNC_ID_W   function id
// - cmd_data0/1  in   DATA_W      operands
// - req_valid    out  1           CXU-L2 request valid
// - req_ready    in   1           CXU-L2 request ready
// - req_id       out  REQ_ID_W    request tag
// - req_cxu/state/func/data0/data1  out  as cmd_*  request fields
// - resp_valid   in   1           CXU-L2 response valid
// - resp_ready   out  1           CXU-L2 response ready; tied 1
// - resp_id      in   REQ_ID_W    response tag
// - resp_status  in   $bits(cxu_status_t)  response status
// - resp_data    in   DATA_W      response result
// - rsp_valid    out  1           in-order result valid to core
// - rsp_ready    in   1           core accepts result
// - rsp_status   out  $bits(cxu_status_t)  status of the oldest request
// - rsp_data     out  DATA_W      result of the oldest request
// - outstanding  out  REQ_ID_W+1  occupied ROB slots
// - err_proto    out  1           sticky flag: a response arrived for a slot that is not pending
//
// BEHAVIOUR
// - Reset state:
//   - head = tail = 0, count = 0.
//   - All slot pending/done bits are 0.
//   - rsp_valid = 0, err_proto = 0, outstanding = 0, req_valid = 0.
// - Issue path (combinational pass-through, 0-cycle latency):
//   - full = (count == 2**REQ_ID_W).
//   - req_valid = cmd_valid & ~full.
//   - cmd_ready = req_ready & ~full.
//   - req_id = tail; all other req_* fields = cmd_* fields.
//   - A fire (req_valid & req_ready) sets pending[tail], then tail++ (wraps modulo depth).
// - Response path:
//   - resp_ready is constant 1; the ROB slot is reserved at issue, so there is no backpressure.
//   - resp_valid with pending[resp_id] & ~done[resp_id]: store status and data, set done[resp_id].
//   - Otherwise: discard the beat, set err_proto; ROB state is unchanged.
// - Retire path:
//   - rsp_valid = done[head]; rsp_* driven from slot[head] (registered storage, read combinationally).
//   - Minimum latency resp -> rsp is 1 cycle.
//   - On retire (rsp_valid & rsp_ready): clear pending[head] and done[head], then head++ (wraps).
// - count update:
//   - +1 on issue; -1 on retire; unchanged when both occur in the same cycle.
//   - outstanding = count.
// - Boundaries and simultaneous events:
//   - Full: cmd_ready = 0 and req_valid = 0 until a retire; a retire and an issue may occur in the same cycle that frees the slot only on the next cycle.
//   - Empty: rsp_valid = 0.
//   - A response and a retire of the same slot in one cycle cannot occur: that slot is not yet done.
//   - Response to the head slot while rsp_ready = 1: rsp_valid rises next cycle.
//   - Wrap-around of head and tail is plain modulo 2**REQ_ID_W; full and empty are distinguished by count.
// - Reset mid-operation:
//   - All in-flight tags are dropped and the ROB is emptied.
//   - Responders must be reset together with this block; a stray late response sets err_proto.
// - Ordering: rsp order equals cmd acceptance order regardless of resp arrival order.
//
// STRUCTURE
// - cxu_pkg: cxu_status_t and cfid_t (existing). Add typedef cxu_req_id_t (REQ_ID_W) and localparam ROB_DEPTH.
// - One sub-module: cxu_rob (storage plus pending/done bits, head/tail/count).
//   - Write port: (id, status, data).
//   - Alloc and retire strobes.
// - Top level: issue gating and protocol-error detection only.
//
// TESTING
// 1. Single op: cmd cxu=0 func=0 data0=3 data1=4 into a 1-cycle mulacc.
//    -> req_id=0; rsp_data=12 with status OK; outstanding returns to 0.
// 2. Reorder: issue to cxu2 (latency 5) and then cxu0 (latency 1); cxu0 resp arrives first.
//    -> rsp stays invalid until cxu2 resp arrives; then cxu2 result, then cxu0 result on consecutive cycles.
// 3. Full: hold rsp_ready=0 and issue 4 cmds.
//    -> 5th cmd sees cmd_ready=0 and outstanding=4; one retire admits it; tags wrap to 0.
// 4. Backpressure: req_ready=0 for 3 cycles with cmd_valid=1.
//    -> no fire, tail and fields stable, cmd_ready=0; issue happens on the first ready cycle.
// 5. Protocol error: resp_valid with resp_id=2 while slot 2 is idle.
//    -> err_proto=1 (sticky); ROB unchanged; the next legal op completes normally.
// 6. Async reset: assert rst_n=0 mid-stream with 3 outstanding.
//    -> immediately outstanding=0, rsp_valid=0, req_valid=0; after release, the first issue uses req_id=0.

Source files
------------

// File: rtl/cxu_pkg.sv
// Shared CXU-L2 types: status codes, function ids, request tags and ROB depth.
package cxu_pkg;

  localparam int CFID_W    = 10;
  localparam int REQ_ID_W  = 2;
  localparam int ROB_DEPTH = 2 ** REQ_ID_W;

  typedef logic [CFID_W-1:0]   cfid_t;
  typedef logic [REQ_ID_W-1:0] cxu_req_id_t;

  typedef enum logic [1:0] {
    CXU_OK        = 2'd0,
    CXU_ERR_FUNC  = 2'd1,
    CXU_ERR_STATE = 2'd2,
    CXU_ERR_OTHER = 2'd3
  } cxu_status_t;

endpackage

// File: rtl/cxu_rob.sv
// Reorder buffer: one slot per request tag, allocated at issue, filled by
// out-of-order responses and retired strictly from the head.
module cxu_rob
  import cxu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_i,
  input  logic              retire_i,
  input  logic              wr_en_i,
  input  logic [ID_W-1:0]   wr_id_i,
  input  cxu_status_t       wr_status_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [ID_W-1:0]   tail_o,
  output logic [ID_W:0]     count_o,
  output logic              full_o,
  output logic [(2**ID_W)-1:0] pending_o,
  output logic [(2**ID_W)-1:0] done_o,
  output logic              head_done_o,
  output cxu_status_t       head_status_o,
  output logic [DATA_W-1:0] head_data_o
);

  localparam int DEPTH = 2 ** ID_W;

  logic [ID_W-1:0]   head_q, tail_q;
  logic [ID_W:0]     count_q, count_d;
  logic [DEPTH-1:0]  pending_q, done_q;
  cxu_status_t       status_q [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];

  // Occupancy: simultaneous alloc and retire leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (alloc_i && !retire_i)      count_d = count_q + 1'b1;
    else if (!alloc_i && retire_i) count_d = count_q - 1'b1;
  end

  // Slot storage, pending/done flags and head/tail pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      done_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        status_q[i] <= CXU_OK;
        data_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (alloc_i) begin
        pending_q[tail_q] <= 1'b1;
        tail_q            <= tail_q + 1'b1;
      end
      if (wr_en_i) begin
        done_q[wr_id_i]   <= 1'b1;
        status_q[wr_id_i] <= wr_status_i;
        data_q[wr_id_i]   <= wr_data_i;
      end
      if (retire_i) begin
        pending_q[head_q] <= 1'b0;
        done_q[head_q]    <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
    end
  end

  assign tail_o        = tail_q;
  assign count_o       = count_q;
  assign full_o        = (count_q == DEPTH[ID_W:0]);
  assign pending_o     = pending_q;
  assign done_o        = done_q;
  assign head_done_o   = done_q[head_q];
  assign head_status_o = status_q[head_q];
  assign head_data_o   = data_q[head_q];

endmodule

// File: rtl/cxu_l2_requester.sv
// CXU-L2 requester: tags core commands, issues them downstream and returns
// results to the core in issue order through the ROB.
module cxu_l2_requester
  import cxu_pkg::*;
#(
  parameter int N_CXUS    = 3,
  parameter int N_STATES  = 1,
  parameter int FUNC_ID_W = 10,
  parameter int DATA_W    = 32,
  parameter int REQ_ID_W  = cxu_pkg::REQ_ID_W,
  localparam int CXU_ID_W   = $clog2(N_CXUS),
  localparam int STATE_ID_W = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CXU_ID_W-1:0]   cmd_cxu,
  input  logic [STATE_ID_W-1:0] cmd_state,
  input  logic [FUNC_ID_W-1:0]  cmd_func,
  input  logic [DATA_W-1:0]     cmd_data0,
  input  logic [DATA_W-1:0]     cmd_data1,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [REQ_ID_W-1:0]   req_id,
  output logic [CXU_ID_W-1:0]   req_cxu,
  output logic [STATE_ID_W-1:0] req_state,
  output logic [FUNC_ID_W-1:0]  req_func,
  output logic [DATA_W-1:0]     req_data0,
  output logic [DATA_W-1:0]     req_data1,
  input  logic                  resp_valid,
  output logic                  resp_ready,
  input  logic [REQ_ID_W-1:0]   resp_id,
  input  cxu_status_t           resp_status,
  input  logic [DATA_W-1:0]     resp_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output cxu_status_t           rsp_status,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [REQ_ID_W:0]     outstanding,
  output logic                  err_proto
);

  localparam int DEPTH = 2 ** REQ_ID_W;

  logic                full;
  logic                fire;
  logic                retire;
  logic                resp_legal;
  logic [REQ_ID_W-1:0] tail;
  logic [DEPTH-1:0]    pending, done;
  logic                err_proto_q, err_proto_d;

  assign req_valid = cmd_valid & ~full;
  assign cmd_ready = req_ready & ~full;
  assign fire      = req_valid & req_ready;
  assign req_id    = tail;
  assign req_cxu   = cmd_cxu;
  assign req_state = cmd_state;
  assign req_func  = cmd_func;
  assign req_data0 = cmd_data0;
  assign req_data1 = cmd_data1;

  // Slots are reserved at issue, so responses never need to be stalled.
  assign resp_ready = 1'b1;
  assign resp_legal = resp_valid & pending[resp_id] & ~done[resp_id];
  assign retire     = rsp_valid & rsp_ready;

  // Any response to an idle or already-completed slot latches the error flag.
  always_comb begin
    err_proto_d = err_proto_q;
    if (resp_valid && !resp_legal) err_proto_d = 1'b1;
  end

  // Sticky protocol-error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_proto_q <= 1'b0;
    else        err_proto_q <= err_proto_d;
  end

  assign err_proto = err_proto_q;

  cxu_rob #(
    .DATA_W (DATA_W),
    .ID_W   (REQ_ID_W)
  ) u_rob (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_i       (fire),
    .retire_i      (retire),
    .wr_en_i       (resp_legal),
    .wr_id_i       (resp_id),
    .wr_status_i   (resp_status),
    .wr_data_i     (resp_data),
    .tail_o        (tail),
    .count_o       (outstanding),
    .full_o        (full),
    .pending_o     (pending),
    .done_o        (done),
    .head_done_o   (rsp_valid),
    .head_status_o (rsp_status),
    .head_data_o   (rsp_data)
  );

endmodule

// File: tb/tb_cxu_l2_requester.sv
module tb_cxu_l2_requester;
  import cxu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_cxu;
  logic [0:0]  cmd_state;
  logic [9:0]  cmd_func;
  logic [31:0] cmd_data0, cmd_data1;
  logic        req_valid, req_ready;
  logic [1:0]  req_id, req_cxu;
  logic [0:0]  req_state;
  logic [9:0]  req_func;
  logic [31:0] req_data0, req_data1;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_id;
  cxu_status_t resp_status;
  logic [31:0] resp_data;
  logic        rsp_valid, rsp_ready;
  cxu_status_t rsp_status;
  logic [31:0] rsp_data;
  logic [2:0]  outstanding;
  logic        err_proto;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cxu_l2_requester dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cxu(cmd_cxu), .cmd_state(cmd_state),
    .cmd_func(cmd_func), .cmd_data0(cmd_data0), .cmd_data1(cmd_data1),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_cxu(req_cxu),
    .req_state(req_state), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_status(resp_status), .resp_data(resp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .outstanding(outstanding), .err_proto(err_proto)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_cmd(input logic [1:0] cxu, input logic [9:0] func,
                           input logic [31:0] d0, input logic [31:0] d1);
    cmd_valid = 1'b1;
    cmd_cxu   = cxu;
    cmd_state = 1'b0;
    cmd_func  = func;
    cmd_data0 = d0;
    cmd_data1 = d1;
  endtask

  task automatic drive_resp(input logic [1:0] id, input logic [31:0] d);
    resp_valid  = 1'b1;
    resp_id     = id;
    resp_status = CXU_OK;
    resp_data   = d;
  endtask

  task automatic idle();
    cmd_valid  = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); req_ready = 1'b1; rsp_ready = 1'b1;
    cmd_cxu = '0; cmd_state = '0; cmd_func = '0; cmd_data0 = '0; cmd_data1 = '0;
    resp_id = '0; resp_status = CXU_OK; resp_data = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    vectors++; if (err_proto !== 1'b0) begin miscompares++; $display("FAIL reset_err_proto: got %b expected 0", err_proto); end
    vectors++; if (resp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_resp_ready: got %b expected 1", resp_ready); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_single();
    drive_cmd(2'd0, 10'd0, 32'd3, 32'd4);
    #1;
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL single_req_valid: got %b expected 1", req_valid); end
    vectors++; if (req_id !== 2'd0) begin miscompares++; $display("FAIL single_req_id: got %0d expected 0", req_id); end
    vectors++; if (req_data0 !== 32'd3 || req_data1 !== 32'd4) begin miscompares++; $display("FAIL single_req_data: got %0d/%0d expected 3/4", req_data0, req_data1); end
    step(); idle();
    vectors++; if (outstanding !== 3'd1) begin miscompares++; $display("FAIL single_outstanding1: got %0d expected 1", outstanding); end
    drive_resp(2'd0, 32'd12);
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_rsp_early: got %b expected 0", rsp_valid); end
    step(); idle();
    #1;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
    vectors++; if (rsp_data !== 32'd12) begin miscompares++; $display("FAIL single_rsp_data: got %0d expected 12", rsp_data); end
    vectors++; if (rsp_status !== CXU_OK) begin miscompares++; $display("FAIL single_rsp_status: got %0d expected 0", rsp_status); end
    step();
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL single_outstanding0: got %0d expected 0", outstanding); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_reorder();
    drive_cmd(2'd2, 10'd5, 32'd5, 32'd6);
    #1;
    vectors++; if (req_id !== 2'd1 || req_cxu !== 2'd2) begin miscompares++; $display("FAIL reorder_req_a: got id %0d cxu %0d expected 1 2", req_id, req_cxu); end
    step();
    drive_cmd(2'd0, 10'd1, 32'd7, 32'd8);
    #1;
    vectors++; if (req_id !== 2'd2) begin miscompares++; $display("FAIL reorder_req_b: got %0d expected 2", req_id); end
    step(); idle();
    drive_resp(2'd2, 32'd56);
    step(); idle();
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reorder_hold: got %b expected 0", rsp_valid); end
    vectors++; if (outstanding !== 3'd2) begin miscompares++; $display("FAIL reorder_outstanding: got %0d expected 2", outstanding); end
    step(); step();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reorder_hold2: got %b expected 0", rsp_valid); end
    drive_resp(2'd1, 32'd30);
    step(); idle();
    #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd30) begin miscompares++; $display("FAIL reorder_first: got v%b %0d expected v1 30", rsp_valid, rsp_data); end
    step();
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd56) begin miscompares++; $display("FAIL reorder_second: got v%b %0d expected v1 56", rsp_valid, rsp_data); end
    step();
    vectors++; if (rsp_valid !== 1'b0 || outstanding !== 3'd0) begin miscompares++; $display("FAIL reorder_empty: got v%b out %0d expected v0 out 0", rsp_valid, outstanding); end
  endtask

  task automatic test_full();
    logic [1:0]  exp_id [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [31:0] exp_d  [4] = '{32'd100, 32'd101, 32'd102, 32'd200};
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(2'(i % 3), 10'(i), 32'(i), 32'd0);
      #1;
      vectors++; if (req_id !== exp_id[i]) begin miscompares++; $display("FAIL full_req_id%0d: got %0d expected %0d", i, req_id, exp_id[i]); end
      step();
    end
    drive_cmd(2'd1, 10'd9, 32'd200, 32'd0);
    #1;
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL full_cmd_ready: got %b expected 0", cmd_ready); end
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL full_req_valid: got %b expected 0", req_valid); end
    vectors++; if (outstanding !== 3'd4) begin miscompares++; $display("FAIL full_outstanding: got %0d expected 4", outstanding); end
    for (int i = 0; i < 4; i++) begin
      drive_resp(exp_id[i], 32'd100 + 32'(exp_id[i]));
      step();
    end
    resp_valid = 1'b0;
    #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd103) begin miscompares++; $display("FAIL full_head: got v%b %0d expected v1 103", rsp_valid, rsp_data); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL full_still_blocked: got %b expected 0", cmd_ready); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    vectors++; if (cmd_ready !== 1'b1 || req_id !== 2'd3) begin miscompares++; $display("FAIL full_admit: got rdy %b id %0d expected rdy 1 id 3", cmd_ready, req_id); end
    vectors++; if (outstanding !== 3'd3) begin miscompares++; $display("FAIL full_after_retire: got %0d expected 3", outstanding); end
    step(); idle();
    vectors++; if (outstanding !== 3'd4) begin miscompares++; $display("FAIL full_refill: got %0d expected 4", outstanding); end
    drive_resp(2'd3, 32'd200);
    step(); idle();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d[k]) begin miscompares++; $display("FAIL full_drain%0d: got v%b %0d expected v1 %0d", k, rsp_valid, rsp_data, exp_d[k]); end
      step();
    end
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL full_drained: got %0d expected 0", outstanding); end
  endtask

  task automatic test_backpressure();
    req_ready = 1'b0;
    drive_cmd(2'd1, 10'd7, 32'hA5, 32'h5A);
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (cmd_ready !== 1'b0 || req_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hs%0d: got rdy %b v %b expected rdy 0 v 1", c, cmd_ready, req_valid); end
      vectors++; if (req_id !== 2'd0 || req_data0 !== 32'hA5 || req_func !== 10'd7) begin miscompares++; $display("FAIL bp_fields%0d: got id %0d d0 %0h f %0d expected 0 a5 7", c, req_id, req_data0, req_func); end
      vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL bp_nofire%0d: got %0d expected 0", c, outstanding); end
      step();
    end
    req_ready = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready: got %b expected 1", cmd_ready); end
    step(); idle();
    vectors++; if (outstanding !== 3'd1) begin miscompares++; $display("FAIL bp_fired: got %0d expected 1", outstanding); end
    drive_resp(2'd0, 32'd77);
    step(); idle();
    #1;
    vectors++; if (rsp_data !== 32'd77) begin miscompares++; $display("FAIL bp_rsp: got %0d expected 77", rsp_data); end
    step();
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL bp_done: got %0d expected 0", outstanding); end
  endtask

  task automatic test_proto();
    drive_resp(2'd2, 32'd55);
    #1;
    vectors++; if (err_proto !== 1'b0) begin miscompares++; $display("FAIL proto_pre: got %b expected 0", err_proto); end
    step(); idle();
    #1;
    vectors++; if (err_proto !== 1'b1) begin miscompares++; $display("FAIL proto_set: got %b expected 1", err_proto); end
    vectors++; if (outstanding !== 3'd0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL proto_rob: got out %0d v %b expected 0 0", outstanding, rsp_valid); end
    drive_cmd(2'd0, 10'd0, 32'd6, 32'd7);
    #1;
    vectors++; if (req_id !== 2'd1) begin miscompares++; $display("FAIL proto_next_id: got %0d expected 1", req_id); end
    step(); idle();
    drive_resp(2'd1, 32'd42);
    step(); idle();
    #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd42) begin miscompares++; $display("FAIL proto_legal: got v%b %0d expected v1 42", rsp_valid, rsp_data); end
    step();
    vectors++; if (err_proto !== 1'b1 || outstanding !== 3'd0) begin miscompares++; $display("FAIL proto_sticky: got err %b out %0d expected 1 0", err_proto, outstanding); end
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(2'd1, 10'd3, 32'(i), 32'd1);
      step();
    end
    idle();
    drive_resp(2'd2, 32'd11);
    step(); idle();
    #1;
    vectors++; if (outstanding !== 3'd3 || rsp_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre: got out %0d v %b expected 3 1", outstanding, rsp_valid); end
    rst_n = 1'b0;
    #1;
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL arst_outstanding: got %0d expected 0", outstanding); end
    vectors++; if (rsp_valid !== 1'b0 || req_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valids: got rsp %b req %b expected 0 0", rsp_valid, req_valid); end
    vectors++; if (err_proto !== 1'b0) begin miscompares++; $display("FAIL arst_err: got %b expected 0", err_proto); end
    step();
    rst_n = 1'b1;
    step();
    drive_resp(2'd2, 32'd9);
    step(); idle();
    #1;
    vectors++; if (err_proto !== 1'b1) begin miscompares++; $display("FAIL arst_stray: got %b expected 1", err_proto); end
    drive_cmd(2'd0, 10'd0, 32'd1, 32'd1);
    #1;
    vectors++; if (req_id !== 2'd0) begin miscompares++; $display("FAIL arst_first_id: got %0d expected 0", req_id); end
    step(); idle();
    vectors++; if (outstanding !== 3'd1) begin miscompares++; $display("FAIL arst_issue: got %0d expected 1", outstanding); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_reorder();
    test_full();
    test_backpressure();
    test_proto();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
